// File: rtl/line_reader_pkg.sv
// Shared camera definitions: line reader FSM encodings and frame geometry
// defaults common to the line buffer and its reader.
package line_reader_pkg;

    localparam int H_DEFAULT = 752;
    localparam int V_DEFAULT = 480;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LINE = 3'd1,
        FETCH     = 3'd2,
        CAPTURE   = 3'd3,
        PRESENT   = 3'd4,
        RELEASE   = 3'd5
    } state_t;

    // A zero-width bus is illegal, so a 1-entry dimension still gets one bit.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_reader.sv
// Line buffer consumer: dumps a frame one line at a time, streaming each pixel
// byte over a valid/ready interface and releasing the buffer after every line.
module line_reader
    import line_reader_pkg::*;
#(
    parameter int H         = H_DEFAULT,
    parameter int V         = V_DEFAULT,
    parameter int LINE_STEP = 1,
    localparam int AW       = index_width(H),
    localparam int LW       = index_width(V)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    output logic [LW-1:0] INTERESTING_LINE,
    input  logic          WHOLE_LINE_READY_FLAG,
    output logic [AW-1:0] READ_ADDRESS,
    input  logic [7:0]    DATA_OUT,
    output logic          RESET_READY_FLAG,
    output logic [7:0]    TX_DATA,
    output logic          TX_VALID,
    input  logic          TX_READY,
    output logic          BUSY,
    output logic          DONE
);

    // Wide enough that line + step never wraps before the compare against V.
    localparam int NW = LW + $clog2(LINE_STEP) + 1;

    state_t        state_q, state_d;
    logic [LW-1:0] line_q, line_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          release_q, release_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [NW-1:0] next_line;
    logic          last_line;
    logic          last_column;

    assign next_line   = NW'(line_q) + NW'(LINE_STEP);
    assign last_line   = (next_line >= NW'(V));
    assign last_column = (addr_q == AW'(H - 1));

    // NOTE: every variable gets its hold value before the case statement, so
    // no path through the decode can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        addr_d     = addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        release_d  = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    line_d  = '0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = WAIT_LINE;
                end
            end

            WAIT_LINE: begin
                if (WHOLE_LINE_READY_FLAG) begin
                    state_d = FETCH;
                end
            end

            // Address is held here while the buffer registers its read data.
            FETCH: begin
                state_d = CAPTURE;
            end

            CAPTURE: begin
                tx_data_d  = DATA_OUT;
                tx_valid_d = 1'b1;
                state_d    = PRESENT;
            end

            PRESENT: begin
                if (TX_READY) begin
                    tx_valid_d = 1'b0;
                    if (last_column) begin
                        // Registered pulse: high for exactly the RELEASE cycle.
                        release_d = 1'b1;
                        state_d   = RELEASE;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = FETCH;
                    end
                end
            end

            RELEASE: begin
                addr_d = '0;
                if (last_line) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    line_d  = LW'(next_line);
                    state_d = WAIT_LINE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            line_q     <= '0;
            addr_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            release_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            addr_q     <= addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            release_q  <= release_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign INTERESTING_LINE = line_q;
    assign READ_ADDRESS     = addr_q;
    assign RESET_READY_FLAG = release_q;
    assign TX_DATA          = tx_data_q;
    assign TX_VALID         = tx_valid_q;
    assign BUSY             = busy_q;
    assign DONE             = done_q;

endmodule
